// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU slice.
//   SEL_*  : operand-Y select codes understood by arithmetic_circuit
//   state_e: sequencer FSM states (2 bits)
package alu_pkg;

    localparam logic [1:0] SEL_ADD   = 2'b00;  // Y = B
    localparam logic [1:0] SEL_ADDNB = 2'b01;  // Y = ~B
    localparam logic [1:0] SEL_PASS  = 2'b10;  // Y = 0
    localparam logic [1:0] SEL_ALL1  = 2'b11;  // Y = all ones

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/arithmetic_circuit.sv
// One-bit arithmetic stage: d = a + y + cin, with y chosen by sel.
//   a_i, b_i : operand bits
//   cin_i    : carry in
//   sel_i    : Y select (see alu_pkg SEL_*)
//   d_o      : sum bit
//   cout_o   : carry out
module arithmetic_circuit
    import alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic [1:0] sel_i,
    output logic       d_o,
    output logic       cout_o
);

    logic y;

    always_comb begin
        y = b_i;
        case (sel_i)
            SEL_ADD:   y = b_i;
            SEL_ADDNB: y = ~b_i;
            SEL_PASS:  y = 1'b0;
            SEL_ALL1:  y = 1'b1;
            default:   y = b_i;
        endcase
    end

    assign d_o    = a_i ^ y ^ cin_i;
    assign cout_o = (a_i & y) | (a_i & cin_i) | (y & cin_i);

endmodule

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial sequencer around arithmetic_circuit. Accepts WIDTH-bit operands,
// walks them LSB first through the 1-bit stage (one bit per cycle) and returns
// sum, carry-out and signed overflow.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   in_valid_i / in_ready_o  : operand handshake (ready only in IDLE)
//   a_i, b_i, sel_i, cin_i   : operands, Y select, initial carry
//   out_valid_o / out_ready_i: result handshake
//   res_o, cout_o, ovf_o     : result, carry out of MSB, signed overflow
//   busy_o                   : high while bits are being processed
module bit_serial_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       sel_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] res_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh, b_sh, res_q;
    logic [1:0]        sel_q;
    logic              carry_q, cout_q, ovf_q;
    logic [CW-1:0]     cnt_q;
    logic              st_d, st_cout;
    logic              accept, last;

    arithmetic_circuit u_stage (
        .a_i    (a_sh[0]),
        .b_i    (b_sh[0]),
        .cin_i  (carry_q),
        .sel_i  (sel_q),
        .d_o    (st_d),
        .cout_o (st_cout)
    );

    assign accept = in_valid_i && (state_q == ST_IDLE);
    assign last   = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid_i)   state_d = ST_RUN;
            ST_RUN:  if (last)         state_d = ST_DONE;
            ST_DONE: if (out_ready_i)  state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sel_q   <= SEL_ADD;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_sh    <= a_i;
            b_sh    <= b_i;
            sel_q   <= sel_i;
            carry_q <= cin_i;
            cnt_q   <= '0;
        end else if (state_q == ST_RUN) begin
            // Result fills from the top: after WIDTH shifts bit 0 lands at res_q[0].
            res_q   <= {st_d, res_q[WIDTH-1:1]};
            carry_q <= st_cout;
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                cout_q <= st_cout;
                // carry_q here is the carry into the MSB.
                ovf_q  <= carry_q ^ st_cout;
            end
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign busy_o      = (state_q == ST_RUN);
    assign out_valid_o = (state_q == ST_DONE);
    assign res_o       = res_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
module tb_bit_serial_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, res;
    logic [1:0]   sel;
    logic         cin, cout, ovf, busy;

    int errors = 0;
    int checks = 0;

    // Expectation shared with the compare process.
    logic         exp_pending = 1'b0;
    logic [W-1:0] exp_res;
    logic         exp_cout, exp_ovf;

    always #5 clk = ~clk;

    bit_serial_alu_seq #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .sel_i       (sel),
        .cin_i       (cin),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .res_o       (res),
        .cout_o      (cout),
        .ovf_o       (ovf),
        .busy_o      (busy)
    );

    // Reference: plain wide addition, overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                           input logic [1:0] fs, input logic fc);
        logic [W-1:0] y;
        logic [W:0]   sum;
        logic         v;
        case (fs)
            2'b00:   y = fb;
            2'b01:   y = ~fb;
            2'b10:   y = '0;
            default: y = '1;
        endcase
        sum = {1'b0, fa} + {1'b0, y} + {{W{1'b0}}, fc};
        v   = (fa[W-1] == y[W-1]) && (sum[W-1] != fa[W-1]);
        return {sum[W], v, sum[W-1:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Compare process: every cycle a result is presented it must match the model.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (!exp_pending) begin
                chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("res",      32'(res),      32'(exp_res));
                chk("cout",     32'(cout),     32'(exp_cout));
                chk("ovf",      32'(ovf),      32'(exp_ovf));
                chk("in_ready_in_done", 32'(in_ready), 32'd0);
            end
        end
    end

    // Caller is positioned at a negedge; returns at a negedge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [1:0] ts,
                          input logic tc, input int stall, input bit pulse);
        int n;
        logic [W+1:0] m;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        a = ta; b = tb_; sel = ts; cin = tc; in_valid = 1'b1;
        m = model(ta, tb_, ts, tc);
        exp_res = m[W-1:0]; exp_ovf = m[W]; exp_cout = m[W+1];
        exp_pending = 1'b1;
        @(negedge clk);
        // Operands may change freely once accepted.
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sel = 2'($urandom); cin = 1'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        n = 0;
        while (out_valid !== 1'b1 && n < W + 5) begin
            in_valid = pulse && (n == 3);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(n), 32'(W));
        for (int i = 0; i < stall; i++) begin
            in_valid = pulse;
            a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_pending = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W+1:0] m;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sel = 2'b00; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_res",       32'(res),       32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Pin the model with hand-computed results ({cout, ovf, res}).
        m = model(8'h5A, 8'h33, 2'b00, 1'b0); chk("model_add",  32'(m), 32'h18D);
        m = model(8'h10, 8'h20, 2'b01, 1'b1); chk("model_sub1", 32'(m), 32'h0F0);
        m = model(8'h80, 8'h01, 2'b01, 1'b1); chk("model_sub2", 32'(m), 32'h37F);
        m = model(8'hFF, 8'h00, 2'b10, 1'b1); chk("model_inc",  32'(m), 32'h200);
        m = model(8'h00, 8'h00, 2'b11, 1'b0); chk("model_dec",  32'(m), 32'h0FF);

        // Directed vectors, back-to-back (each accept on the cycle in_ready rises).
        run_op(8'h5A, 8'h33, 2'b00, 1'b0, 0, 1'b0);
        run_op(8'h10, 8'h20, 2'b01, 1'b1, 0, 1'b0);
        run_op(8'h80, 8'h01, 2'b01, 1'b1, 0, 1'b0);
        run_op(8'hFF, 8'h00, 2'b10, 1'b1, 0, 1'b0);
        run_op(8'h00, 8'h00, 2'b11, 1'b0, 0, 1'b0);

        // Backpressure with ignored in_valid pulses in RUN and DONE.
        run_op(8'hC3, 8'h5C, 2'b00, 1'b1, 5, 1'b1);
        run_op(8'h7F, 8'h80, 2'b01, 1'b0, 0, 1'b0);

        // Reset mid-RUN after bit 3.
        a = 8'hAA; b = 8'h55; sel = 2'b00; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_res",       32'(res),       32'd0);
        run_op(8'h01, 8'h01, 2'b00, 1'b0, 0, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 30; k++) begin
            run_op(W'($urandom), W'($urandom), 2'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
